pcie_triple_fifo_sched: RTL

- Shares one 16-in/128-out asynchronous FIFO (8-bit write depth, 5-bit read depth, non-registered output) between three 16-bit stream sources of the PCIe triple-transfer path.
- Write side: round-robin arbiter grants one source for exactly one 128-bit line (8 beats), so lines never mix sources.
- Read side: drains lines into a 2-entry output buffer and tags each line with its source ID.

---
 rtl/pcie_triple_fifo_sched_pkg.sv | 28 ++
 rtl/pcie_sched_tag_fifo.sv | 70 +++++++
 rtl/pcie_triple_fifo_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/pcie_triple_fifo_sched_pkg.sv
// Shared constants and types for the PCIe triple-transfer FIFO scheduler.
//   BEATS       : write beats that make up one read line
//   SRC_W       : width of a source ID / line tag
//   wr_state_t  : write-side arbiter states
//   tag_t       : source ID carried with every line
//   line_t      : read line plus its source tag
package pcie_triple_fifo_sched_pkg;

   localparam int unsigned WR_DATA_WIDTH   = 16;
   localparam int unsigned RD_DATA_WIDTH   = 128;
   localparam int unsigned BEATS           = RD_DATA_WIDTH / WR_DATA_WIDTH;
   localparam int unsigned BEAT_CNT_W      = $clog2(BEATS);
   localparam int unsigned SRC_W           = 2;
   localparam int unsigned TAG_DEPTH_WIDTH = 5;

   typedef enum logic {
      IDLE,
      BURST
   } wr_state_t;

   typedef logic [SRC_W-1:0] tag_t;

   typedef struct packed {
      tag_t                     src;
      logic [RD_DATA_WIDTH-1:0] data;
   } line_t;

endpackage

// File: rtl/pcie_sched_tag_fifo.sv
// Synchronous tag queue that remembers the source of every line in the
// shared FIFO, in write order. Show-ahead read: pop_data_c is the head.
//   clk, tb_rst  : clock, async active-high reset
//   push         : enqueue push_data
//   push_data    : tag to enqueue
//   pop          : dequeue head
//   pop_data_c   : current head (combinational)
module pcie_sched_tag_fifo
   import pcie_triple_fifo_sched_pkg::*;
#(
   parameter int unsigned DEPTH_W = TAG_DEPTH_WIDTH,
   parameter int unsigned DATA_W  = SRC_W
) (
   input  logic              clk,
   input  logic              tb_rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data_c
);

   localparam int unsigned DEPTH = 2 ** DEPTH_W;

   logic [DATA_W-1:0]  mem [DEPTH];
   logic [DEPTH_W-1:0] wr_ptr_q;
   logic [DEPTH_W-1:0] rd_ptr_q;
   logic [DEPTH_W:0]   cnt_q;
   logic               empty_c;
   logic               full_c;

   assign empty_c    = (cnt_q == '0);
   assign full_c     = (cnt_q == (DEPTH_W+1)'(DEPTH));
   assign pop_data_c = mem[rd_ptr_q];

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + DEPTH_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + DEPTH_W'(1);
         end
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + (DEPTH_W+1)'(1);
            2'b01:   cnt_q <= cnt_q - (DEPTH_W+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // The line FIFO has exactly as many line slots as this queue, so
   // either condition means the surrounding logic is broken.
   a_no_overflow: assert property (@(posedge clk) disable iff (tb_rst) !(push && full_c))
      else $error("tag queue push while full");
   a_no_underflow: assert property (@(posedge clk) disable iff (tb_rst) !(pop && empty_c))
      else $error("tag queue pop while empty");

endmodule

// File: rtl/pcie_triple_fifo_sched.sv
// Shares one 16-in/128-out FIFO between N_SRC 16-bit sources. The write side
// grants one source for a whole 8-beat line (round robin); the read side
// drains lines into a 2-entry buffer and tags each with its source ID.
//   clk, tb_rst                 : clock, async active-high reset
//   req_valid/req_data/req_ready: per-source beat handshake
//   fifo_wr_*                   : FIFO write port and flags
//   fifo_rd_*                   : FIFO read port (data 1 cycle after rd_en)
//   out_valid/out_data/out_src/out_ready : tagged line output
module pcie_triple_fifo_sched
   import pcie_triple_fifo_sched_pkg::*;
#(
   parameter int unsigned N_SRC = 3
) (
   input  logic                             clk,
   input  logic                             tb_rst,
   input  logic [N_SRC-1:0]                 req_valid,
   input  logic [N_SRC*WR_DATA_WIDTH-1:0]   req_data,
   output logic [N_SRC-1:0]                 req_ready,
   output logic                             fifo_wr_en,
   output logic [WR_DATA_WIDTH-1:0]         fifo_wr_data,
   input  logic                             fifo_wr_full,
   input  logic                             fifo_almost_full,
   output logic                             fifo_rd_en,
   input  logic [RD_DATA_WIDTH-1:0]         fifo_rd_data,
   input  logic                             fifo_rd_empty,
   output logic                             out_valid,
   output logic [RD_DATA_WIDTH-1:0]         out_data,
   output logic [SRC_W-1:0]                 out_src,
   input  logic                             out_ready
);

   wr_state_t               state_q, state_d;
   tag_t                    gnt_q, gnt_d;
   tag_t                    last_grant_q, last_grant_d;
   logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic                    tag_push;

   logic                    arb_found;
   tag_t                    arb_next;
   logic                    sel_valid;
   logic [WR_DATA_WIDTH-1:0] sel_data;

   // First valid source after last_grant, searched cyclically.
   always_comb begin
      arb_found = 1'b0;
      arb_next  = last_grant_q;
      for (int unsigned k = 1; k <= N_SRC; k++) begin
         for (int unsigned j = 0; j < N_SRC; j++) begin
            if (!arb_found && req_valid[j] &&
                (j == (32'(last_grant_q) + k) % N_SRC)) begin
               arb_next  = SRC_W'(j);
               arb_found = 1'b1;
            end
         end
      end
   end

   // Beat of the currently granted source.
   always_comb begin
      sel_valid = 1'b0;
      sel_data  = '0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (gnt_q == SRC_W'(i)) begin
            sel_valid = req_valid[i];
            sel_data  = req_data[i*WR_DATA_WIDTH +: WR_DATA_WIDTH];
         end
      end
   end

   // Write FSM state register.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         state_q      <= IDLE;
         gnt_q        <= '0;
         last_grant_q <= SRC_W'(N_SRC - 1);
         beat_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         gnt_q        <= gnt_d;
         last_grant_q <= last_grant_d;
         beat_cnt_q   <= beat_cnt_d;
      end
   end

   // Write FSM next state and beat handshake. The grant is held until the
   // line completes; almost_full only gates new grants.
   always_comb begin
      state_d      = state_q;
      gnt_d        = gnt_q;
      last_grant_d = last_grant_q;
      beat_cnt_d   = beat_cnt_q;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      fifo_wr_data = '0;
      tag_push     = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_found && !fifo_almost_full) begin
               gnt_d   = arb_next;
               state_d = BURST;
            end
         end
         BURST: begin
            for (int unsigned i = 0; i < N_SRC; i++) begin
               if (gnt_q == SRC_W'(i)) begin
                  req_ready[i] = !fifo_wr_full;
               end
            end
            fifo_wr_en   = sel_valid && !fifo_wr_full;
            fifo_wr_data = sel_data;
            if (sel_valid && !fifo_wr_full) begin
               if (beat_cnt_q == BEAT_CNT_W'(BEATS - 1)) begin
                  tag_push     = 1'b1;
                  last_grant_d = gnt_q;
                  beat_cnt_d   = '0;
                  state_d      = IDLE;
               end else begin
                  beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- read side ----------------
   logic        inflight_q;
   logic [1:0]  occ_q;
   line_t       skid_q [2];
   tag_t        tag_head;
   line_t       cap_line;
   logic        pop_c;

   pcie_sched_tag_fifo #(
      .DEPTH_W (TAG_DEPTH_WIDTH),
      .DATA_W  (SRC_W)
   ) u_tag_fifo (
      .clk        (clk),
      .tb_rst     (tb_rst),
      .push       (tag_push),
      .push_data  (gnt_q),
      .pop        (inflight_q),
      .pop_data_c (tag_head)
   );

   // Read only when the buffer can hold the line already in flight plus this one.
   assign fifo_rd_en = !tb_rst && !fifo_rd_empty &&
                       ((3'(occ_q) + 3'(inflight_q)) < 3'd2);
   assign out_valid  = (occ_q != 2'd0);
   assign out_data   = skid_q[0].data;
   assign out_src    = skid_q[0].src;
   assign pop_c      = out_valid && out_ready;
   assign cap_line   = '{src: tag_head, data: fifo_rd_data};

   // Two-entry output buffer; entry 0 is always the head, so the output
   // stays stable while stalled.
   always_ff @(posedge clk or posedge tb_rst) begin
      if (tb_rst) begin
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
         skid_q[0]  <= '0;
         skid_q[1]  <= '0;
      end else begin
         inflight_q <= fifo_rd_en;
         case ({inflight_q, pop_c})
            2'b10: begin
               skid_q[occ_q[0]] <= cap_line;
               occ_q            <= occ_q + 2'd1;
            end
            2'b01: begin
               skid_q[0] <= skid_q[1];
               occ_q     <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  skid_q[0] <= cap_line;
               end else begin
                  skid_q[0] <= skid_q[1];
                  skid_q[1] <= cap_line;
               end
            end
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule
